// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: state encoding, bus width, default
// wiring mask and a small index helper.
package bus_arbiter_pkg;

  localparam int          BUS_W              = 32;
  localparam logic [31:0] DEFAULT_VALID_MASK = 32'h02FF_FFFF;
  localparam int          HOLD_CNT_W         = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OWN    = 2'd2,
    TURN   = 2'd3
  } arb_state_e;

  // Next index after idx, wrapping at n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    int nxt;
    nxt = idx + 1;
    if (nxt >= n) begin
      nxt = 0;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_priority_pick.sv
// Round-robin winner search: rotate the request vector so rr_ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_priority_pick #(
  parameter int NUM_SRC = 32,
  parameter int SEL_W   = 5
) (
  input  logic [NUM_SRC-1:0] eff_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic [SEL_W-1:0]   winner_o,
  output logic               found_o
);

  logic [2*NUM_SRC-1:0] dbl_s;
  logic [NUM_SRC-1:0]   rot_s;
  logic [SEL_W:0]       idx_s;
  logic [SEL_W:0]       sum_s;

  // Rotate, priority-encode (lowest bit wins), un-rotate modulo NUM_SRC.
  always_comb begin
    dbl_s = {eff_i, eff_i} >> ptr_i;
    rot_s = dbl_s[NUM_SRC-1:0];
    idx_s = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      idx_s = rot_s[i] ? (SEL_W+1)'(i) : idx_s;
    end
    sum_s = idx_s + {1'b0, ptr_i};
    if (sum_s >= (SEL_W+1)'(NUM_SRC)) begin
      winner_o = SEL_W'(sum_s - (SEL_W+1)'(NUM_SRC));
    end else begin
      winner_o = sum_s[SEL_W-1:0];
    end
    found_o = |eff_i;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared processor bus; drives the select of
// the registered bus mux and flags when the mux output carries the owner's data.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int          NUM_SRC    = 32,
  parameter int          SEL_W      = 5,
  parameter logic [31:0] VALID_MASK = DEFAULT_VALID_MASK,
  parameter int          HOLD_MAX   = 16
) (
  input  logic               clk_i,
  input  logic               clear_i,
  input  logic [NUM_SRC-1:0] req_i,
  input  logic               release_i,
  output logic [NUM_SRC-1:0] grant_o,
  output logic [SEL_W-1:0]   select_o,
  output logic               bus_valid_o,
  output logic               bus_busy_o,
  output logic               timeout_o
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_C = HOLD_CNT_W'(HOLD_MAX);

  arb_state_e              state_q, state_d;
  logic [NUM_SRC-1:0]      grant_q, grant_d;
  logic [SEL_W-1:0]        select_q, select_d;
  logic [SEL_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [HOLD_CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                    bus_valid_q, bus_valid_d;
  logic                    bus_busy_q, bus_busy_d;
  logic                    timeout_q, timeout_d;

  logic [NUM_SRC-1:0]      eff_s;
  logic [SEL_W-1:0]        win_s;
  logic                    found_s;
  logic                    owner_req_s;
  logic                    own_exit_s;

  assign eff_s       = req_i & VALID_MASK[NUM_SRC-1:0];
  assign owner_req_s = req_i[select_q];

  rr_priority_pick #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_pick (
    .eff_i    (eff_s),
    .ptr_i    (rr_ptr_q),
    .winner_o (win_s),
    .found_o  (found_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    select_d   = select_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    own_exit_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (found_s) begin
          grant_d  = {{(NUM_SRC-1){1'b0}}, 1'b1} << win_s;
          select_d = win_s;
          state_d  = SETTLE;
        end else begin
          state_d  = IDLE;
        end
      end
      SETTLE: begin
        hold_cnt_d = HOLD_CNT_W'(1);
        state_d    = OWN;
      end
      OWN: begin
        own_exit_s = release_i | ~owner_req_s | (hold_cnt_q == HOLD_C);
        if (own_exit_s) begin
          grant_d    = '0;
          rr_ptr_d   = SEL_W'(wrap_inc(int'(select_q), NUM_SRC));
          hold_cnt_d = '0;
          state_d    = TURN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
          state_d    = OWN;
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        hold_cnt_d = '0;
      end
    endcase

    // Flags are decoded from the next state so they line up with the OWN cycles.
    bus_valid_d = (state_d == OWN);
    timeout_d   = (state_d == OWN) && (hold_cnt_d == HOLD_C);
    bus_busy_d  = (state_d != IDLE);
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      select_q    <= '0;
      rr_ptr_q    <= '0;
      hold_cnt_q  <= '0;
      bus_valid_q <= 1'b0;
      bus_busy_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      select_q    <= select_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      bus_valid_q <= bus_valid_d;
      bus_busy_q  <= bus_busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant_o     = grant_q;
  assign select_o    = select_q;
  assign bus_valid_o = bus_valid_q;
  assign bus_busy_o  = bus_busy_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural owner model.
module tb_bus_arbiter;

  localparam int          N    = 32;
  localparam int          HOLD = 16;
  localparam logic [31:0] MASK = 32'h02FF_FFFF;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] req = 32'h0;
  logic        rel = 1'b0;
  logic [31:0] grant;
  logic [4:0]  select;
  logic        bus_valid, bus_busy, timeout;

  int n_chk = 0;
  int n_fail = 0;

  // Model: who owns the bus, how many cycles since the grant, turnaround flag.
  int m_owner = -1;
  int m_age   = 0;
  int m_cool  = 0;
  int m_ptr   = 0;
  int m_sel   = 0;

  bus_arbiter #(.NUM_SRC(N), .SEL_W(5), .VALID_MASK(MASK), .HOLD_MAX(HOLD)) dut (
    .clk_i       (clk),
    .clear_i     (clear),
    .req_i       (req),
    .release_i   (rel),
    .grant_o     (grant),
    .select_o    (select),
    .bus_valid_o (bus_valid),
    .bus_busy_o  (bus_busy),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [31:0] r, input logic rl, input logic clr);
    bit found;
    if (clr) begin
      m_owner = -1; m_age = 0; m_cool = 0; m_ptr = 0; m_sel = 0;
    end else if (m_owner >= 0) begin
      if (m_age == 0) m_age = 1;
      else if (rl || !r[m_owner] || m_age == HOLD) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_age = 0; m_cool = 1;
      end else m_age++;
    end else if (m_cool != 0) begin
      m_cool = 0;
    end else begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int s;
        s = (m_ptr + k) % N;
        if (!found && r[s] && MASK[s]) begin
          found = 1'b1; m_owner = s; m_sel = s; m_age = 0;
        end
      end
    end
  endtask

  task automatic compare_model();
    logic [31:0] eg;
    logic        ev;
    eg = (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0;
    ev = (m_owner >= 0) && (m_age >= 1);
    chk("grant", grant, eg);
    chk("select", 32'(select), 32'(m_sel));
    chk("bus_valid", 32'(bus_valid), 32'(ev));
    chk("bus_busy", 32'(bus_busy), 32'((m_owner >= 0) || (m_cool != 0)));
    chk("timeout", 32'(timeout), 32'(ev && (m_age == HOLD)));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(req, rel, clear);
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_clear();
    clear = 1'b1; rel = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int order[4];
    int n;
    int vcnt, tcnt, tpos;

    // Reset state
    tick(); tick();
    chk("rst_grant", grant, 32'h0);
    chk("rst_select", 32'(select), 32'h0);
    chk("rst_valid", 32'(bus_valid), 32'h0);
    chk("rst_busy", 32'(bus_busy), 32'h0);
    clear = 1'b0;

    // Single request
    req = 32'h1 << 5;
    tick();
    chk("single_grant", grant, 32'h20);
    chk("single_select", 32'(select), 32'd5);
    chk("single_valid_settle", 32'(bus_valid), 32'h0);
    tick();
    chk("single_valid", 32'(bus_valid), 32'h1);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    chk("rel_grant", grant, 32'h0);
    chk("rel_valid", 32'(bus_valid), 32'h0);
    req = 32'h0;
    tick();
    req = (32'h1 << 5) | (32'h1 << 7);
    tick();
    chk("rrptr6_select", 32'(select), 32'd7);
    req = 32'h0;
    repeat (4) tick();

    // Round-robin fairness
    do_clear();
    req = (32'h1 << 3) | (32'h1 << 7) | (32'h1 << 20);
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!bus_valid && n < 20) begin
        tick(); n++;
      end
      chk("rr_wait_bound", 32'(bus_valid), 32'h1);
      order[g] = int'(select);
      if (g > 0) chk("rr_gap", 32'(n), 32'd3);
      tick();
      rel = 1'b1;
      tick();
      rel = 1'b0;
    end
    chk("rr_order0", 32'(order[0]), 32'd3);
    chk("rr_order1", 32'(order[1]), 32'd7);
    chk("rr_order2", 32'(order[2]), 32'd20);
    chk("rr_order3", 32'(order[3]), 32'd3);

    // Timeout
    do_clear();
    req = 32'h1;
    vcnt = 0; tcnt = 0; tpos = 0;
    for (int t = 1; t <= 21; t++) begin
      tick();
      if (t <= 20) begin
        vcnt += int'(bus_valid);
        if (timeout) begin tcnt++; tpos = t; end
      end else begin
        chk("to_regrant_valid", 32'(bus_valid), 32'h1);
        chk("to_regrant_grant", grant, 32'h1);
      end
    end
    chk("to_valid_cycles", 32'(vcnt), 32'd16);
    chk("to_pulses", 32'(tcnt), 32'd1);
    chk("to_position", 32'(tpos), 32'd17);

    // Mask and wrap: owner 25 leaves rr_ptr at 26, 24/26 are unwired
    do_clear();
    req = 32'h1 << 25;
    tick();
    chk("own25_select", 32'(select), 32'd25);
    req = 32'h0;
    tick(); tick(); tick();
    req = (32'h1 << 24) | (32'h1 << 26) | (32'h1 << 2);
    tick();
    chk("wrap_select", 32'(select), 32'd2);
    chk("wrap_grant", grant, 32'h4);
    req = 32'h0;
    repeat (4) tick();
    do_clear();
    req = 32'h1 << 24;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("masked_busy", 32'(bus_busy), 32'h0);
      chk("masked_grant", grant, 32'h0);
    end

    // Reset mid-operation
    req = 32'h1 << 9;
    do_clear();
    tick(); tick(); tick();
    chk("mid_valid_pre", 32'(bus_valid), 32'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("mid_grant", grant, 32'h0);
    chk("mid_select", 32'(select), 32'h0);
    chk("mid_valid", 32'(bus_valid), 32'h0);
    chk("mid_busy", 32'(bus_busy), 32'h0);
    tick();
    chk("mid_regrant", grant, 32'h200);
    chk("mid_reselect", 32'(select), 32'd9);

    // Release together with hold limit: one exit, rr_ptr advances once
    req = 32'h1;
    do_clear();
    repeat (17) tick();
    chk("sim_timeout", 32'(timeout), 32'h1);
    rel = 1'b1;
    req = 32'h7;
    tick();
    rel = 1'b0;
    chk("sim_valid", 32'(bus_valid), 32'h0);
    chk("sim_timeout_drop", 32'(timeout), 32'h0);
    tick(); tick();
    chk("sim_next_owner", 32'(select), 32'd1);

    // Randomized traffic
    req = 32'h0;
    do_clear();
    for (int c = 0; c < 4000; c++) begin
      case ($urandom_range(0, 7))
        0: req = $urandom;
        1: req = $urandom & $urandom & $urandom;
        2: req = req ^ (32'h1 << $urandom_range(0, 31));
        3: req = 32'h1 << $urandom_range(0, 31);
        default: req = req;
      endcase
      rel   = ($urandom_range(0, 9) == 0);
      clear = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
